// File: rtl/boolean_scan_pkg.sv
// Shared types and sizes for the boolean inverse scanner.
// BOOLSCAN_EARLY_STOP_EN (see boolean_inverse_scanner) does not affect this package.
package boolean_scan_pkg;

    localparam int unsigned VEC_W            = 4;
    localparam int unsigned CNT_W            = 5;
    localparam int unsigned LAST_IDX_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // True when an evaluated (e, f) pair equals the latched target.
    function automatic logic hits_target(
        input logic e,
        input logic f,
        input logic target_e,
        input logic target_f
    );
        return (e == target_e) && (f == target_f);
    endfunction

endpackage

// File: rtl/boolean_eval.sv
// Combinational evaluator: E = A + BC + B'D, F = B'C + BC'D', vec = {A,B,C,D}.
module boolean_eval
    import boolean_scan_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             e,
    output logic             f
);

    logic a, b, c, d;

    always_comb begin
        a = vec[3];
        b = vec[2];
        c = vec[1];
        d = vec[0];
        e = a | (b & c) | (~b & d);
        f = (~b & c) | (b & ~c & ~d);
    end

endmodule

// File: rtl/boolean_inverse_scanner.sv
// Enumerates every {A,B,C,D} in 0..LAST_IDX whose (E,F) equals a target, one per handshake.
// Define BOOLSCAN_EARLY_STOP_EN to finish the scan after the first accepted match.
module boolean_inverse_scanner
    import boolean_scan_pkg::*;
#(
    parameter int unsigned LAST_IDX = LAST_IDX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             target_e,
    input  logic             target_f,
    output logic             match_valid,
    output logic [VEC_W-1:0] match_vec,
    input  logic             match_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [VEC_W-1:0] LAST = LAST_IDX[VEC_W-1:0];

    state_e           state_q;
    logic [VEC_W-1:0] idx_q;
    logic             te_q;
    logic             tf_q;
    logic             valid_q;
    logic [VEC_W-1:0] vec_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic eval_e;
    logic eval_f;
    logic hit;
    logic is_last;

    boolean_eval u_eval (
        .vec (idx_q),
        .e   (eval_e),
        .f   (eval_f)
    );

    always_comb begin
        hit     = hits_target(eval_e, eval_f, te_q, tf_q);
        is_last = (idx_q == LAST);
    end

    // idx is never advanced past LAST, so the 4-bit counter cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            te_q    <= 1'b0;
            tf_q    <= 1'b0;
            valid_q <= 1'b0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        te_q    <= target_e;
                        tf_q    <= target_f;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        vec_q   <= idx_q;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else if (is_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (match_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + 1'b1;
`ifdef BOOLSCAN_EARLY_STOP_EN
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`else
                        if (is_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SCAN;
                        end
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        match_valid = valid_q;
        match_vec   = vec_q;
        busy        = busy_q;
        done        = done_q;
        match_count = cnt_q;
    end

endmodule

// File: tb/tb_boolean_inverse_scanner.sv
// Directed bench for boolean_inverse_scanner (default LAST_IDX and LAST_IDX=4 instances).
module tb_boolean_inverse_scanner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic       target_e;
    logic       target_f;
    logic       match_ready;
    logic       match_valid;
    logic [3:0] match_vec;
    logic       busy;
    logic       done;
    logic [4:0] match_count;
    logic       match_valid4;
    logic [3:0] match_vec4;
    logic       busy4;
    logic       done4;
    logic [4:0] match_count4;

    int n_vec = 0;
    int n_err = 0;

    boolean_inverse_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .target_e    (target_e),
        .target_f    (target_f),
        .match_valid (match_valid),
        .match_vec   (match_vec),
        .match_ready (match_ready),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    boolean_inverse_scanner #(.LAST_IDX(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .target_e    (target_e),
        .target_f    (target_f),
        .match_valid (match_valid4),
        .match_vec   (match_vec4),
        .match_ready (match_ready),
        .busy        (busy4),
        .done        (done4),
        .match_count (match_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulses start for one edge; returns 1 time unit after the accepting edge.
    task automatic do_start(input logic e, input logic f);
        @(negedge clk);
        start    = 1'b1;
        target_e = e;
        target_f = f;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        target_e = 1'b0; target_f = 1'b0; match_ready = 1'b0;
        #12;
        n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", match_valid); end
        n_vec++; if (match_vec !== 4'd0) begin n_err++; $display("FAIL reset_vec got=%0d exp=0", match_vec); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (match_count !== 5'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

`ifndef BOOLSCAN_EARLY_STOP_EN
    task automatic test_ready_high();
        logic [3:0] exp [4] = '{4'd3, 4'd10, 4'd11, 4'd12};
        logic [3:0] got [$];
        int cyc;
        match_ready = 1'b1;
        do_start(1'b1, 1'b1);
        cyc = 1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rh_busy_first got=%b exp=1", busy); end
        while (done !== 1'b1 && cyc < 200) begin
            if (match_valid === 1'b1) got.push_back(match_vec);
            @(posedge clk); #1; cyc++;
        end
        n_vec++; if (cyc !== 21) begin n_err++; $display("FAIL rh_latency got=%0d exp=21", cyc); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rh_busy_done got=%b exp=0", busy); end
        n_vec++; if (match_count !== 5'd4) begin n_err++; $display("FAIL rh_count got=%0d exp=4", match_count); end
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL rh_nmatch got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL rh_vec[%0d] got=%0d exp=%0d", i, got[i], exp[i]);
            end
        end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rh_done_pulse got=%b exp=0", done); end
        n_vec++; if (match_count !== 5'd4) begin n_err++; $display("FAIL rh_count_hold got=%0d exp=4", match_count); end
    endtask

    task automatic test_held_ready();
        logic [3:0] exp [8] = '{4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd14, 4'd15};
        logic [3:0] got [$];
        logic [3:0] v;
        logic       stable;
        int cyc;
        match_ready = 1'b0;
        do_start(1'b1, 1'b0);
        cyc = 1;
        n_vec++; if (match_count !== 5'd0) begin n_err++; $display("FAIL hr_count_clear got=%0d exp=0", match_count); end
        while (done !== 1'b1 && cyc < 400) begin
            if (match_valid === 1'b1) begin
                v = match_vec;
                stable = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1; cyc++;
                    if (match_valid !== 1'b1 || match_vec !== v) stable = 1'b0;
                end
                n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL hr_stable vec=%0d now=%0d valid=%b", v, match_vec, match_valid); end
                match_ready = 1'b1;
                got.push_back(v);
                @(posedge clk); #1; cyc++;
                match_ready = 1'b0;
            end else begin
                @(posedge clk); #1; cyc++;
            end
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL hr_timeout got done=%b exp=1", done); end
        n_vec++; if (match_count !== 5'd8) begin n_err++; $display("FAIL hr_count got=%0d exp=8", match_count); end
        n_vec++; if (got.size() != 8) begin n_err++; $display("FAIL hr_nmatch got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL hr_vec[%0d] got=%0d exp=%0d", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_last_idx4();
        logic [3:0] got [$];
        int cyc;
        match_ready = 1'b1;
        @(negedge clk);
        start4 = 1'b1; target_e = 1'b0; target_f = 1'b0;
        @(posedge clk); #1 start4 = 1'b0;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 100) begin
            if (match_valid4 === 1'b1) got.push_back(match_vec4);
            @(posedge clk); #1; cyc++;
        end
        n_vec++; if (cyc !== 7) begin n_err++; $display("FAIL l4_latency got=%0d exp=7", cyc); end
        n_vec++; if (match_count4 !== 5'd1) begin n_err++; $display("FAIL l4_count got=%0d exp=1", match_count4); end
        n_vec++; if (got.size() != 1 || got[0] !== 4'd0) begin n_err++; $display("FAIL l4_vec got_n=%0d first=%0d exp=0", got.size(), got[0]); end
    endtask

    task automatic test_start_while_busy();
        logic [3:0] exp [4] = '{4'd3, 4'd10, 4'd11, 4'd12};
        logic [3:0] got [$];
        int cyc;
        match_ready = 1'b1;
        do_start(1'b1, 1'b1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (match_valid === 1'b1) got.push_back(match_vec);
            start    = (cyc == 5 || cyc == 10);
            target_e = 1'b0;
            target_f = (cyc == 10);
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        n_vec++; if (cyc !== 21) begin n_err++; $display("FAIL sb_latency got=%0d exp=21", cyc); end
        n_vec++; if (match_count !== 5'd4) begin n_err++; $display("FAIL sb_count got=%0d exp=4", match_count); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                n_err++; $display("FAIL sb_vec[%0d] got=%0d exp=%0d", i, got[i], exp[i]);
            end
        end
        repeat (2) @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sb_idle_after got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_emit();
        logic [3:0] got [$];
        int cyc;
        match_ready = 1'b0;
        do_start(1'b0, 1'b1);
        cyc = 1;
        while (match_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        n_vec++; if (match_vec !== 4'd2) begin n_err++; $display("FAIL rm_first_vec got=%0d exp=2", match_vec); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%b exp=0", match_valid); end
        n_vec++; if (match_vec !== 4'd0) begin n_err++; $display("FAIL rm_vec got=%0d exp=0", match_vec); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0 || match_count !== 5'd0) begin n_err++; $display("FAIL rm_done_count got=%b/%0d exp=0/0", done, match_count); end
        @(negedge clk); rst_n = 1'b1;
        match_ready = 1'b1;
        do_start(1'b0, 1'b1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (match_valid === 1'b1) got.push_back(match_vec);
            @(posedge clk); #1; cyc++;
        end
        n_vec++; if (match_count !== 5'd2) begin n_err++; $display("FAIL rm_count got=%0d exp=2", match_count); end
        n_vec++; if (got.size() != 2 || got[0] !== 4'd2 || got[1] !== 4'd4) begin
            n_err++; $display("FAIL rm_vecs got_n=%0d v0=%0d v1=%0d exp=2,4", got.size(), got[0], got[1]);
        end
    endtask
`else
    task automatic test_early_stop();
        logic [3:0] got [$];
        int cyc;
        match_ready = 1'b1;
        do_start(1'b1, 1'b0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (match_valid === 1'b1) got.push_back(match_vec);
            @(posedge clk); #1; cyc++;
        end
        n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL es_latency got=%0d exp=4", cyc); end
        n_vec++; if (match_count !== 5'd1) begin n_err++; $display("FAIL es_count got=%0d exp=1", match_count); end
        n_vec++; if (got.size() != 1 || got[0] !== 4'd1) begin n_err++; $display("FAIL es_vec got_n=%0d first=%0d exp=1", got.size(), got[0]); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL es_busy got=%b exp=0", busy); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef BOOLSCAN_EARLY_STOP_EN
        test_ready_high();
        test_held_ready();
        test_last_idx4();
        test_start_while_busy();
        test_reset_mid_emit();
`else
        test_early_stop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/boolean_inverse_scanner.md
# boolean_inverse_scanner

Sequential inverse of the two-output boolean function E = A + BC + B'D, F = B'C + BC'D'. Given a target (E, F) pair, it steps through the 4-bit input space {A,B,C,D} and emits every input vector that produces the target, one per valid/ready handshake. It ends with a done pulse and a match count. It sits beside the combinational evaluator as its reverse-direction companion, used for self-checking and for preimage enumeration.

## Interface
- LAST_IDX, default 15: highest candidate index scanned (range 0..15). The scan always starts at 0.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request; accepted only in IDLE.
- target_e  input  1  target E value, sampled on accepted start.
- target_f  input  1  target F value, sampled on accepted start.
- match_valid  output  1  match_vec holds a matching input vector.
- match_vec  output  4  matching vector {A,B,C,D}, A is the MSB.
- match_ready  input  1  consumer accepts match_vec when high together with match_valid.
- busy  output  1  high in SCAN and EMIT.
- done  output  1  one-cycle pulse at the end of a scan.
- match_count  output  5  number of matches emitted in the last scan; held until the next accepted start.

## Operation
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - start=1 latches target_e/target_f, clears idx and match_count, then goes to SCAN.
  - start is ignored in every other state.
- SCAN evaluates E/F for candidate idx combinationally.
  - Match: register match_vec<=idx and match_valid<=1, then go to EMIT. idx is not advanced.
  - No match, idx==LAST_IDX: go to DONE.
  - No match otherwise: idx<=idx+1.
- EMIT holds match_valid, match_vec and idx stable until match_ready=1. On that handshake cycle:
  - match_valid<=0 and match_count<=match_count+1.
  - If idx==LAST_IDX, go to DONE; otherwise idx<=idx+1 and go to SCAN.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=0 in DONE.
- idx is 4 bits and never wraps. The LAST_IDX comparison terminates the scan before any overflow.
- match_count is 5 bits so a full count of 16 is representable.
- Reference match sets:
  - (E,F)=(0,0): {0,5}
  - (1,0): {1,6,7,8,9,13,14,15}
  - (0,1): {2,4}
  - (1,1): {3,10,11,12}

## Timing
- Reset values: match_valid=0, match_vec=0, busy=0, done=0, match_count=0, state=IDLE.
- rst_n low at any time, including mid-scan or mid-EMIT, clears all of the above immediately. The pending match is dropped.
- start is accepted at edge N. busy=1 and the SCAN of idx 0 start in cycle N+1.
- Each non-matching candidate takes 1 cycle. Each matching candidate takes 1 SCAN cycle plus the EMIT cycles until the handshake.
- With match_ready tied high, start to done takes 1 + (LAST_IDX+1) + matches cycles.
- match_valid never deasserts without a handshake. match_vec is stable while match_valid=1.

## Configuration
- BOOLSCAN_EARLY_STOP_EN defined: the first accepted match goes straight to DONE. match_count is then at most 1.
- Undefined: every match in 0..LAST_IDX is emitted.

## Structure
- Package boolean_scan_pkg holds:
  - the state enum {IDLE, SCAN, EMIT, DONE}
  - VEC_W=4 and CNT_W=5
  - the default LAST_IDX=15
- One sub-module, boolean_eval: purely combinational. Inputs are vec[3:0]; outputs are e and f, implementing the function above. It is instantiated once on idx.

## Test plan
- Reset, then start with target (1,1) and match_ready=1 -> vectors 3,10,11,12 in order; done 21 cycles after the start edge; match_count=4.
- Target (1,0) with match_ready low for 3 cycles at each match -> match_vec stable while held; 8 handshakes: 1,6,7,8,9,13,14,15; match_count=8.
- Target (0,0) with LAST_IDX=4 -> match 0 only; done; match_count=1.
- start pulsed while busy, with different targets -> ignored; the original scan result is unchanged.
- rst_n asserted during EMIT of vector 2 (target (0,1)) -> all outputs 0 immediately. A new start afterwards yields 2,4 and count 2.
- BOOLSCAN_EARLY_STOP_EN defined, target (1,0) -> single match 1; done; match_count=1.
